// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues word-aligned fetches, splits each word into
// 16-bit parcels, rebuilds RV32C/RV32I instructions (including ones that
// straddle a word boundary), and buffers them with their PC in a small FIFO.
module inst_fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter int          PTR_BIT  = 3,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               redirect_in,
  input  logic [31:0]        redirect_pc,
  output logic               fetch_req_out,
  output logic [31:0]        fetch_addr_out,
  input  logic               fetch_valid_in,
  input  logic [31:0]        fetch_data_in,
  output logic               out_valid,
  input  logic               out_ready_in,
  output logic [31:0]        out_inst,
  output logic [31:0]        out_pc,
  output logic               out_is_c,
  output logic [PTR_BIT:0]   count_out
);

  // A launch needs room for the worst case of two enqueues per response.
  localparam logic [PTR_BIT:0] LAUNCH_MAX = (PTR_BIT+1)'(DEPTH - 2);

  logic [31:0] fifo_inst [DEPTH];
  logic [31:0] fifo_pc   [DEPTH];
  logic        fifo_c    [DEPTH];

  logic [PTR_BIT-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr_nx;
  logic [PTR_BIT:0]   count_q, count_d, count_after;
  logic [31:0]        fetch_addr_q, fetch_addr_d;
  logic               offset_q, offset_d;
  logic               hold_valid_q, hold_valid_d;
  logic [15:0]        hold_half_q, hold_half_d;
  logic [31:0]        hold_pc_q, hold_pc_d;
  logic               outstanding_q, outstanding_d;
  logic               discard_q, discard_d;

  logic        deq, launch, resp, drop_resp;
  logic [15:0] lo, hi;
  logic        a_v, b_v, do_hi, hold_set;
  logic [31:0] a_inst, a_pc, b_inst, b_pc;
  logic        a_c;
  logic        s0_v, s1_v, s0_c;
  logic [31:0] s0_inst, s0_pc;
  logic [1:0]  n_enq;
  logic        unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[0];

  assign out_valid      = (count_q != '0);
  assign out_inst       = fifo_inst[rd_ptr_q];
  assign out_pc         = fifo_pc[rd_ptr_q];
  assign out_is_c       = fifo_c[rd_ptr_q];
  assign count_out      = count_q;
  assign fetch_addr_out = fetch_addr_q;
  assign fetch_req_out  = launch;

  assign deq         = rdy_in && !redirect_in && out_valid && out_ready_in;
  assign count_after = count_q - {{PTR_BIT{1'b0}}, deq};
  // Gated by rst_in so no request escapes while reset is asserted.
  assign launch      = rst_in && rdy_in && !redirect_in && !outstanding_q &&
                       (count_after <= LAUNCH_MAX);
  assign resp        = rdy_in && !redirect_in && fetch_valid_in && outstanding_q && !discard_q;
  assign drop_resp   = rdy_in && !redirect_in && fetch_valid_in && outstanding_q && discard_q;
  assign lo          = fetch_data_in[15:0];
  assign hi          = fetch_data_in[31:16];
  assign wr_ptr_nx   = wr_ptr_q + PTR_BIT'(1);

  // Split the response word into at most two instructions (a = lower PC, b = upper half).
  always_comb begin
    a_v    = 1'b0;
    a_inst = 32'h0;
    a_pc   = fetch_addr_q;
    a_c    = 1'b0;
    do_hi  = 1'b0;
    if (hold_valid_q) begin
      a_v    = 1'b1;
      a_inst = {lo, hold_half_q};
      a_pc   = hold_pc_q;
      do_hi  = 1'b1;
    end else if (!offset_q) begin
      a_v = 1'b1;
      if (lo[1:0] == 2'b11) begin
        a_inst = fetch_data_in;
      end else begin
        a_inst = {16'h0, lo};
        a_c    = 1'b1;
        do_hi  = 1'b1;
      end
    end else begin
      do_hi = 1'b1;
    end
    b_inst   = {16'h0, hi};
    b_pc     = fetch_addr_q + 32'd2;
    b_v      = do_hi && (hi[1:0] != 2'b11);
    hold_set = do_hi && (hi[1:0] == 2'b11);
  end

  // Pack the produced instructions into consecutive FIFO slots.
  always_comb begin
    s0_v    = a_v || b_v;
    s1_v    = a_v && b_v;
    s0_inst = a_v ? a_inst : b_inst;
    s0_pc   = a_v ? a_pc   : b_pc;
    s0_c    = a_v ? a_c    : 1'b1;
    n_enq   = resp ? ({1'b0, a_v} + {1'b0, b_v}) : 2'd0;
  end

  // Next-state for pointers, fetch address, hold register and fetch flags.
  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    fetch_addr_d  = fetch_addr_q;
    offset_d      = offset_q;
    hold_valid_d  = hold_valid_q;
    hold_half_d   = hold_half_q;
    hold_pc_d     = hold_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (rdy_in && redirect_in) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      hold_valid_d = 1'b0;
      fetch_addr_d = {redirect_pc[31:2], 2'b00};
      offset_d     = redirect_pc[1];
      if (outstanding_q && fetch_valid_in) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end else if (outstanding_q) begin
        discard_d = 1'b1;
      end
    end else if (rdy_in) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_BIT-1){1'b0}}, deq};
      wr_ptr_d = wr_ptr_q + PTR_BIT'(n_enq);
      count_d  = count_after + (PTR_BIT+1)'(n_enq);
      if (resp) begin
        hold_valid_d  = hold_set;
        if (hold_set) begin
          hold_half_d = hi;
          hold_pc_d   = fetch_addr_q + 32'd2;
        end
        fetch_addr_d  = fetch_addr_q + 32'd4;
        offset_d      = 1'b0;
        outstanding_d = 1'b0;
      end else if (drop_resp) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end else if (launch) begin
        outstanding_d = 1'b1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fetch_addr_q  <= {RESET_PC[31:2], 2'b00};
      offset_q      <= RESET_PC[1];
      hold_valid_q  <= 1'b0;
      hold_half_q   <= 16'h0;
      hold_pc_q     <= 32'h0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      fetch_addr_q  <= fetch_addr_d;
      offset_q      <= offset_d;
      hold_valid_q  <= hold_valid_d;
      hold_half_q   <= hold_half_d;
      hold_pc_q     <= hold_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk_in) begin
    if (resp && s0_v) begin
      fifo_inst[wr_ptr_q] <= s0_inst;
      fifo_pc[wr_ptr_q]   <= s0_pc;
      fifo_c[wr_ptr_q]    <= s0_c;
    end
    if (resp && s1_v) begin
      fifo_inst[wr_ptr_nx] <= b_inst;
      fifo_pc[wr_ptr_nx]   <= b_pc;
      fifo_c[wr_ptr_nx]    <= 1'b1;
    end
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Parametrised fetch front-end that sits between the icache/memory_unit and the decoder.
- Issues word-aligned fetches and splits each 32-bit word into 16-bit parcels.
- Reassembles RV32C and RV32I instructions, including 32-bit instructions that straddle a word boundary.
- Buffers decoded-ready instructions with their PC in a DEPTH-entry FIFO, decoupling fetch from issue stalls; supports redirect/flush at halfword-aligned targets.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 4.
PTR_BIT, 3, log2(DEPTH).
RESET_PC, 32'h0, fetch start address after reset.

Ports:
clk_in  input  1  clock; all state updates on posedge.
rst_in  input  1  asynchronous, active-low reset (asserted when 0).
rdy_in  input  1  global pause; when 0, all state holds (reset still acts).
redirect_in  input  1  flush the queue and restart fetch at redirect_pc.
redirect_pc  input  32  new PC; bit 0 ignored; may be halfword aligned.
fetch_req_out  output  1  one-cycle pulse that launches a fetch of fetch_addr_out.
fetch_addr_out  output  32  word-aligned fetch address; bits [1:0] always 0.
fetch_valid_in  input  1  response for the outstanding fetch.
fetch_data_in  input  32  fetched word, little-endian; low half is the lower address.
out_valid  output  1  FIFO head valid.
out_ready_in  input  1  consumer accepts head this cycle.
out_inst  output  32  instruction; RVC is zero-extended as {16'b0, parcel}.
out_pc  output  32  instruction address.
out_is_c  output  1  head is a compressed instruction.
count_out  output  PTR_BIT+1  occupied entries.

Behaviour:
Reset (rst_in=0, async):
- FIFO empty; out_valid=0; count_out=0.
- fetch_req_out=0; fetch_addr_out=RESET_PC&~3.
- Internal fetch offset = RESET_PC[1].
- Hold register, outstanding flag and discard flag cleared.

Fetch launch:
- Pulse fetch_req_out=1 for exactly one cycle when all of these hold: rdy_in, no outstanding fetch, no redirect_in, free entries >= 2 (free = DEPTH - count after this cycle's dequeue is accounted).
- On launch, set outstanding.
- At most one fetch is in flight. Responses return in order, at least 1 cycle after the launch.

Response processing (fetch_valid_in with outstanding set and discard clear), in one cycle, lo = data[15:0], hi = data[31:16]:
- Hold valid:
  - Enqueue {lo, hold_half} at hold_pc, is_c=0; clear hold.
  - Then process hi.
- No hold, offset 0:
  - If lo[1:0]==2'b11, enqueue the whole word at fetch_addr, is_c=0.
  - Otherwise enqueue lo as RVC at fetch_addr, then process hi.
- No hold, offset 1: process hi only.
- Process hi:
  - If hi[1:0]!=2'b11, enqueue hi as RVC at fetch_addr+2.
  - Otherwise hold_half=hi, hold_pc=fetch_addr+2, hold valid.
- Afterwards: fetch_addr_out += 4; offset=0; clear outstanding.
- At most 2 enqueues per response. The launch rule guarantees space, so overflow is impossible.
- Within one response, enqueue order is ascending PC.

FIFO:
- Circular buffer with wrap-around pointers.
- Dequeue when out_valid && out_ready_in.
- Enqueue and dequeue may occur in the same cycle; count is updated by net change.
- Outputs out_* are combinational from the head entry.
- Data must be stable while out_valid=1 and not accepted.

Redirect (redirect_in=1, rdy_in=1), takes priority over everything:
- Empty the FIFO and clear hold.
- fetch_addr_out = redirect_pc & ~3; offset = redirect_pc[1].
- Any response arriving in the redirect cycle is dropped.
- If a fetch was outstanding and has not completed this cycle: set discard. The next fetch_valid_in is then dropped, clearing discard and outstanding.
- No fetch launches in the redirect cycle. The earliest launch is the next cycle, or the cycle after the discarded response.
- Dequeue in the redirect cycle is ignored; out_valid=0 the next cycle.

rdy_in=0: no pointer, flag or address changes, and fetch_req_out=0. A fetch_valid_in arriving while rdy_in=0 is not permitted by the memory_unit contract.

Test Plan:
- Reset, RESET_PC=0, responses 0x00000013, 0x00100093 with out_ready_in=1 -> outputs (0x00000013, pc 0, is_c=0) then (0x00100093, pc 4); fetch_addr_out=8.
- Word 0x45014501 at addr 0 -> two RVC entries (0x4501, pc 0) and (0x4501, pc 2); count_out=2 with no dequeue.
- Straddle: word 0x00134501 at 0 then 0x1111_0000 at 4 -> RVC (0x4501, pc 0); then held half 0x0013 combines to 32-bit (0x00000013, pc 2); hi 0x1111 is RVC at pc 6.
- Full: out_ready_in=0, DEPTH=8, stream of RVC pairs -> exactly 4 fetch_req_out pulses, count_out=8, no further requests until a dequeue frees 2 entries.
- Redirect to 0x102 while a fetch to 0x20 is outstanding -> FIFO empties; the 0x20 response is dropped; next fetch_addr_out=0x100 and only hi is enqueued at pc 0x102.
- rst_in pulled low mid-response with count_out=5 -> immediately count_out=0, out_valid=0, fetch_addr_out=RESET_PC.
